cu_decode_pipe: RTL and testbench

- Parametrised, registered successor to the combinational control-unit decoder.
- Accepts instruction words over a valid/ready handshake and splits them into opcode, destination (addr1), sources (addr2, addr3) and immediate (number) fields.
- Keeps a register-busy scoreboard so a RAW or WAW hazard stalls issue. A HALT opcode parks the decoder until resume.
- Sits between instruction fetch and the register-file/ALU stage.

---
 rtl/cu_decode_pipe_pkg.sv | 15 +
 rtl/cu_decode_pipe_if.sv | 27 ++
 rtl/cu_decode_pipe_scoreboard.sv | 31 +++
 rtl/cu_decode_pipe.sv | 89 ++++++++
 tb/tb_cu_decode_pipe.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cu_decode_pipe_pkg.sv
// cu_pkg: shared types, default decode constants and field-offset helpers for cu_decode_pipe
package cu_pkg;
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
  localparam logic [3:0] HALT_OP_D = 4'hF;
  localparam logic [15:0] WR_MASK_D = 16'h7FFF;
  function automatic int a1_lsb(int iw, int opw, int aw);
    return iw - opw - aw;
  endfunction
  function automatic int a2_lsb(int iw, int opw, int aw);
    return iw - opw - 2 * aw;
  endfunction
  function automatic int a3_lsb(int iw, int opw, int aw);
    return iw - opw - 3 * aw;
  endfunction
endpackage

// File: rtl/cu_decode_pipe_if.sv
// cu_decode_pipe_if: fetch-side instruction handshake and decoded-field output bus
// master: instruction source / downstream consumer; slave: the decoder
interface cu_decode_pipe_if #(
  parameter int IW = 32,
  parameter int OPW = 4,
  parameter int AW = 5,
  parameter int NW = 8
);
  logic in_valid;
  logic in_ready;
  logic [IW-1:0] instr;
  logic out_valid;
  logic out_ready;
  logic [OPW-1:0] opcode;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr3;
  logic [NW-1:0] number;
  modport master (
    output in_valid, instr, out_ready,
    input in_ready, out_valid, opcode, addr1, addr2, addr3, number
  );
  modport slave (
    input in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, addr1, addr2, addr3, number
  );
endinterface

// File: rtl/cu_decode_pipe_scoreboard.sv
// cu_scoreboard: register-busy vector (set wins over clear, r0 never busy) and hazard lookup
// ports: clk, rst (async high); set_en/set_addr mark a destination busy; clr_en/clr_addr
// release it on writeback; wr/a1/a2/a3 describe the candidate instruction; hazard, busy out
module cu_scoreboard #(
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              wr,
  input  logic [AW-1:0]     a1,
  input  logic [AW-1:0]     a2,
  input  logic [AW-1:0]     a3,
  output logic              hazard,
  output logic [2**AW-1:0]  busy
);
  logic [2**AW-1:0] busy_nxt;
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= busy_nxt;
  assign hazard = busy[a2] | busy[a3] | (wr & busy[a1]);
endmodule

// File: rtl/cu_decode_pipe.sv
// cu_decode_pipe: registered instruction decoder with busy-register hazard stall and HALT/resume
// ports: clk, rst (async high); bus (cu_decode_pipe_if.slave: in_valid/in_ready/instr in,
// out_valid/out_ready/opcode/addr1/addr2/addr3/number out); wb_valid/wb_addr writeback release;
// resume leaves HALT; halted; stall_cnt (counts only when CU_STALL_CNT_EN is defined, else 0)
module cu_decode_pipe
  import cu_pkg::*;
#(
  parameter int IW = 32,
  parameter int OPW = 4,
  parameter int AW = 5,
  parameter int NW = 8,
  parameter logic [OPW-1:0] HALT_OP = HALT_OP_D,
  parameter logic [2**OPW-1:0] WR_MASK = WR_MASK_D
) (
  input  logic          clk,
  input  logic          rst,
  cu_decode_pipe_if.slave bus,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic          resume,
  output logic          halted,
  output logic [15:0]   stall_cnt
);
  localparam int A1L = a1_lsb(IW, OPW, AW);
  localparam int A2L = a2_lsb(IW, OPW, AW);
  localparam int A3L = a3_lsb(IW, OPW, AW);
  state_t state, nxt;
  logic [OPW-1:0] f_op;
  logic [AW-1:0] f_a1, f_a2, f_a3;
  logic [NW-1:0] f_num;
  logic wr, hazard, accept, unused_instr;
  logic [2**AW-1:0] busy;
  assign f_op = bus.instr[IW-1 -: OPW];
  assign f_a1 = bus.instr[A1L +: AW];
  assign f_a2 = bus.instr[A2L +: AW];
  assign f_a3 = bus.instr[A3L +: AW];
  assign f_num = bus.instr[NW-1:0];
  assign unused_instr = ^bus.instr;
  assign wr = WR_MASK[f_op];
  assign accept = bus.in_valid & bus.in_ready;
  cu_scoreboard #(.AW(AW)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(accept & wr), .set_addr(f_a1),
    .clr_en(wb_valid), .clr_addr(wb_addr),
    .wr(wr), .a1(f_a1), .a2(f_a2), .a3(f_a3),
    .hazard(hazard), .busy(busy)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      RUN:     nxt = (accept && f_op == HALT_OP) ? HALT : (bus.in_valid && hazard) ? STALL : RUN;
      STALL:   nxt = hazard ? STALL : RUN;
      default: nxt = resume ? RUN : HALT;
    endcase
  end
  always_comb begin
    halted = state == HALT;
    bus.in_ready = (state == RUN) & !hazard & (!bus.out_valid | bus.out_ready);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.opcode <= '0;
      bus.addr1 <= '0;
      bus.addr2 <= '0;
      bus.addr3 <= '0;
      bus.number <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.opcode <= f_op;
      bus.addr1 <= f_a1;
      bus.addr2 <= f_a2;
      bus.addr3 <= f_a3;
      bus.number <= f_num;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
`ifdef CU_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (bus.in_valid && !bus.in_ready && state != HALT && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cu_decode_pipe.sv
// tb_cu_decode_pipe: directed table-driven and sequence checks of cu_decode_pipe
module tb_cu_decode_pipe;
  import cu_pkg::*;
  logic clk = 0, rst = 1, wb_valid = 0, resume = 0;
  logic [4:0] wb_addr = '0;
  logic halted;
  logic [15:0] stall_cnt;
  int n_cmp = 0, n_fail = 0;
  cu_decode_pipe_if #(.IW(32), .OPW(4), .AW(5), .NW(8)) bus ();
  cu_decode_pipe dut (
    .clk(clk), .rst(rst), .bus(bus), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .resume(resume), .halted(halted), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
`ifdef CU_STALL_CNT_EN
  localparam bit CNT = 1;
`else
  localparam bit CNT = 0;
`endif
  typedef struct {
    logic [31:0] instr;
    logic [3:0] op;
    logic [4:0] a1, a2, a3;
    logic [7:0] num;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] a1, a2, a3, input logic [7:0] n);
    return {op, a1, a2, a3, 5'b0, n};
  endfunction
  initial begin
    vt[0] = '{32'hAFA0AD7A, 4'hA, 5'd31, 5'd8, 5'd5, 8'h7A};
    vt[1] = '{32'h30886011, 4'h3, 5'd1, 5'd2, 5'd3, 8'h11};
    vt[2] = '{32'h0010A0FF, 4'h0, 5'd0, 5'd4, 5'd5, 8'hFF};
    vt[3] = '{32'h00000000, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00};
    vt[4] = '{32'h2200C05A, 4'h2, 5'd4, 5'd0, 5'd6, 8'h5A};
    bus.in_valid = 0; bus.instr = '0; bus.out_ready = 1;
    #12;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_opcode", {28'b0, bus.opcode}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 0);
    chk("rst_busy", dut.u_sb.busy, 0);
    cyc();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.instr = vt[i].instr;
      #1 chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, 1);
      cyc();
      chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, 1);
      chk($sformatf("v%0d_opcode", i), {28'b0, bus.opcode}, {28'b0, vt[i].op});
      chk($sformatf("v%0d_addr1", i), {27'b0, bus.addr1}, {27'b0, vt[i].a1});
      chk($sformatf("v%0d_addr2", i), {27'b0, bus.addr2}, {27'b0, vt[i].a2});
      chk($sformatf("v%0d_addr3", i), {27'b0, bus.addr3}, {27'b0, vt[i].a3});
      chk($sformatf("v%0d_number", i), {24'b0, bus.number}, {24'b0, vt[i].num});
    end
    chk("busy_after_table", dut.u_sb.busy, 32'h8000_0012);
    // RAW on r31
    bus.instr = mk(4'h1, 5'd9, 5'd31, 5'd0, 8'h01);
    #1 chk("raw_in_ready", {31'b0, bus.in_ready}, 0);
    cyc();
    chk("raw_state_stall", {30'b0, dut.state}, {30'b0, STALL});
    chk("raw_drained", {31'b0, bus.out_valid}, 0);
    cyc();
    cyc();
    chk("raw_still_stalled", {31'b0, bus.in_ready}, 0);
    wb_valid = 1; wb_addr = 5'd31;
    cyc();
    wb_valid = 0;
    chk("raw_wb_cleared", {31'b0, dut.u_sb.busy[31]}, 0);
    chk("raw_ready_after_wb", {31'b0, bus.in_ready}, 0);
    cyc();
    chk("raw_ready_resume", {31'b0, bus.in_ready}, 1);
    cyc();
    chk("raw_issue_valid", {31'b0, bus.out_valid}, 1);
    chk("raw_issue_addr1", {27'b0, bus.addr1}, 9);
    chk("raw_stall_cnt", {16'b0, stall_cnt}, CNT ? 5 : 0);
    // backpressure
    bus.instr = mk(4'h5, 5'd10, 5'd0, 5'd0, 8'h22); bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp%0d_in_ready", i), {31'b0, bus.in_ready}, 0);
      cyc();
      chk($sformatf("bp%0d_valid", i), {31'b0, bus.out_valid}, 1);
      chk($sformatf("bp%0d_addr1", i), {27'b0, bus.addr1}, 9);
      chk($sformatf("bp%0d_number", i), {24'b0, bus.number}, 8'h01);
    end
    bus.out_ready = 1;
    #1 chk("bp_release_ready", {31'b0, bus.in_ready}, 1);
    cyc();
    chk("b2b0_addr1", {27'b0, bus.addr1}, 10);
    chk("b2b0_number", {24'b0, bus.number}, 8'h22);
    bus.instr = mk(4'h6, 5'd11, 5'd0, 5'd0, 8'h33);
    #1 chk("b2b1_ready", {31'b0, bus.in_ready}, 1);
    cyc();
    chk("b2b1_addr1", {27'b0, bus.addr1}, 11);
    chk("b2b1_valid", {31'b0, bus.out_valid}, 1);
    chk("bp_stall_cnt", {16'b0, stall_cnt}, CNT ? 8 : 0);
    // HALT
    bus.instr = mk(4'hF, 5'd2, 5'd0, 5'd0, 8'h44);
    #1 chk("halt_accept_ready", {31'b0, bus.in_ready}, 1);
    cyc();
    chk("halt_opcode", {28'b0, bus.opcode}, 4'hF);
    chk("halt_addr1", {27'b0, bus.addr1}, 2);
    chk("halted", {31'b0, halted}, 1);
    chk("halt_no_busy", {31'b0, dut.u_sb.busy[2]}, 0);
    bus.instr = mk(4'h7, 5'd12, 5'd0, 5'd0, 8'h55);
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("halt%0d_in_ready", i), {31'b0, bus.in_ready}, 0);
      chk($sformatf("halt%0d_halted", i), {31'b0, halted}, 1);
      cyc();
    end
    chk("halt_drained", {31'b0, bus.out_valid}, 0);
    chk("halt_stall_cnt", {16'b0, stall_cnt}, CNT ? 8 : 0);
    resume = 1;
    cyc();
    resume = 0;
    chk("resume_halted", {31'b0, halted}, 0);
    chk("resume_ready", {31'b0, bus.in_ready}, 1);
    cyc();
    chk("resume_addr1", {27'b0, bus.addr1}, 12);
    // set/clear collision on r7
    bus.instr = mk(4'h3, 5'd7, 5'd0, 5'd0, 8'h66); wb_valid = 1; wb_addr = 5'd7;
    cyc();
    chk("collide_busy7", {31'b0, dut.u_sb.busy[7]}, 1);
    bus.in_valid = 0;
    cyc();
    wb_valid = 0;
    chk("wb_clear_busy7", {31'b0, dut.u_sb.busy[7]}, 0);
    // reset while halted with pending output and busy registers
    bus.in_valid = 1; bus.instr = mk(4'hF, 5'd3, 5'd5, 5'd6, 8'h77);
    #1 chk("rst_pre_ready", {31'b0, bus.in_ready}, 1);
    cyc();
    bus.in_valid = 0; bus.out_ready = 0;
    chk("rst_pre_halted", {31'b0, halted}, 1);
    chk("rst_pre_valid", {31'b0, bus.out_valid}, 1);
    #3 rst = 1;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("arst_opcode", {28'b0, bus.opcode}, 0);
    chk("arst_addr1", {27'b0, bus.addr1}, 0);
    chk("arst_number", {24'b0, bus.number}, 0);
    chk("arst_halted", {31'b0, halted}, 0);
    chk("arst_busy", dut.u_sb.busy, 0);
    chk("arst_state", {30'b0, dut.state}, {30'b0, RUN});
    chk("arst_stall_cnt", {16'b0, stall_cnt}, 0);
    cyc();
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
